pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It drives the enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles three cases: load-use stalls, branch/jump redirects resolved in the MEM stage, and multi-cycle data-memory waits with a watchdog. It also keeps saturating stall and flush statistics.

## Interface
- WAIT_MAX, 255: consecutive dmem_ready-low cycles before entering ERROR (≥2).
- CNT_W, 16: width of the statistics counters.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low)
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_write_reg  in  5  destination register of the EX instruction
- mem_branch, mem_zero, mem_jump  in  1 each  EX/MEM register outputs
- dmem_req  in  1  MEM stage is accessing data memory (read or write)
- dmem_ready  in  1  data memory completes the access this cycle
- clr_stats  in  1  synchronous clear of the statistics counters
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage hold (0) / advance (1)
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load a bubble; flush dominates enable
- pc_src_sel  out  2  00 sequential, 01 branch target, 10 jump target
- state  out  2  00 RUN, 01 MEM_WAIT, 10 ERROR
- err  out  1  watchdog expired (sticky)
- stall_cnt, flush_cnt  out  CNT_W each  statistics counters

## Operation
- Control outputs are combinational from state and inputs. state, wait_cnt, err and the counters are registered.
- Default in RUN: all enables 1, all flushes 0, pc_src_sel=00.
- load_use = ex_mem_read & (ex_write_reg≠0) & (ex_write_reg==id_rs | (id_uses_rt & ex_write_reg==id_rt)).
- redirect = mem_jump | (mem_branch & mem_zero). mem_jump wins, giving pc_src_sel=10; otherwise pc_src_sel=01.
- Priority in RUN: memory wait > redirect > load-use.
  - Memory wait (dmem_req & !dmem_ready): all enables 0, mem_wb_flush=1. Next state is MEM_WAIT and wait_cnt becomes 1.
  - Redirect: if_id_flush, id_ex_flush and ex_mem_flush are 1, all enables are 1, pc_src_sel is set. flush_cnt increments.
  - Load-use: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en and mem_wb_en stay 1.
- MEM_WAIT with dmem_ready=0:
  - Outputs are frozen as on wait entry.
  - If wait_cnt==WAIT_MAX-1, the next state is ERROR. Otherwise wait_cnt increments.
- MEM_WAIT with dmem_ready=1:
  - Outputs are evaluated exactly as in RUN with the wait term forced false. A pending redirect in EX/MEM is therefore applied this cycle.
  - Next state is RUN.
- ERROR: all enables 0, mem_wb_flush=1, err=1. The block stays in ERROR until reset.
- stall_cnt increments in every cycle with pc_en=0 while not in ERROR.
- Both counters saturate at 2^CNT_W-1. clr_stats clears them and wins over an increment in the same cycle.

## Timing
- Reset (rst low, asynchronous):
  - Registered values: state=RUN, wait_cnt=0, err=0, stall_cnt=0, flush_cnt=0.
  - While rst is low: all enables 0, all flushes 1, pc_src_sel=00.
- Load-use costs exactly 1 bubble. In the next cycle the load is in MEM, the bubble is in EX, and no re-stall occurs.
- A redirect costs 3 flushed instructions. The redirect and the new PC source are effective at the same clock edge.
- A redirect that coincides with load_use: the redirect applies and no stall is counted.
- Memory wait: the freeze starts in the cycle the request is first seen with ready low. The pipeline resumes at the edge where dmem_ready=1 is sampled.
- Watchdog: ERROR is registered at the edge ending the WAIT_MAX-th consecutive ready-low cycle.
- Reset asserted mid-wait: the block returns to RUN immediately; the pending access is abandoned.

## Test plan
- Load-use: ex_mem_read=1, ex_write_reg=5, id_rs=5 for one cycle, then ex_mem_read=0 -> first cycle pc_en=0, if_id_en=0, id_ex_flush=1; second cycle all enables 1; stall_cnt=1.
- Load-use false cases: ex_write_reg=0 with id_rs=0, and id_rt match with id_uses_rt=0 -> no stall.
- Branch taken: mem_branch=1, mem_zero=1 together with load_use=1 -> pc_src_sel=01, IF/ID, ID/EX and EX/MEM flushed, stall_cnt unchanged, flush_cnt=1. mem_jump=1 with mem_branch=1 -> pc_src_sel=10.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles, then high -> 3 frozen cycles with state=01 and stall_cnt=3, then RUN.
- Watchdog with WAIT_MAX=4: ready held low -> err=1 and state=10 after the 4th low cycle; dmem_ready=1 afterwards has no effect; asserting rst clears err.
- Saturation with CNT_W=2: 5 stall cycles -> stall_cnt=3. clr_stats asserted during a stall -> stall_cnt=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Purpose  : Hazard/sequencing controller for a 5-stage MIPS pipeline.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_write_reg_i,
  input  logic             mem_branch_i,
  input  logic             mem_zero_i,
  input  logic             mem_jump_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             clr_stats_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_flush_o,
  output logic             mem_wb_flush_o,
  output logic [1:0]       pc_src_sel_o,
  output logic [1:0]       state_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_ERROR    = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       load_use, redirect, mem_wait, freeze, flush_evt;
  logic [4:0] en;
  logic [3:0] fl;
  logic [1:0] src;

  assign load_use = ex_mem_read_i && (ex_write_reg_i != 5'd0) &&
                    ((ex_write_reg_i == id_rs_i) ||
                     (id_uses_rt_i && (ex_write_reg_i == id_rt_i)));
  assign redirect = mem_jump_i || (mem_branch_i && mem_zero_i);
  assign mem_wait = dmem_req_i && !dmem_ready_i;

  // Freeze covers wait entry, every ready-low wait cycle, and the error trap.
  assign freeze = ((state_q == S_RUN) && mem_wait) ||
                  ((state_q == S_MEM_WAIT) && !dmem_ready_i) ||
                  (state_q == S_ERROR);

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    en        = 5'b11111;
    fl        = 4'b0000;
    src       = 2'b00;
    flush_evt = 1'b0;
    if (freeze) begin
      en = 5'b00000;
      fl = 4'b0001;
    end else if (redirect) begin
      fl        = 4'b1110;
      src       = mem_jump_i ? 2'b10 : 2'b01;
      flush_evt = 1'b1;
    end else if (load_use) begin
      en = 5'b00111;
      fl = 4'b0100;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready_i) begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == C_WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    err_d       = err_q || (state_d == S_ERROR);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_stats_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!en[4] && (state_q != S_ERROR) && (stall_cnt_q != C_CNT_MAX))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != C_CNT_MAX))
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held every stage is stopped and loaded with a bubble.
  always_comb begin
    if (!rst_ni) begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = 5'b00000;
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o} = 4'b1111;
      pc_src_sel_o = 2'b00;
    end else begin
      {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o} = en;
      {if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o} = fl;
      pc_src_sel_o = src;
    end
  end

  assign state_o     = state_q;
  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Purpose  : Scoreboard bench for pipeline_ctrl (WAIT_MAX=4, CNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_pipeline_ctrl;

  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 2;

  // {pc,if_id,id_ex,ex_mem,mem_wb enables}_{if_id,id_ex,ex_mem,mem_wb flushes}_{pc_src}
  localparam logic [10:0] RUNV = 11'b11111_0000_00;
  localparam logic [10:0] LUV  = 11'b00111_0100_00;
  localparam logic [10:0] FRZV = 11'b00000_0001_00;
  localparam logic [10:0] BRV  = 11'b11111_1110_01;
  localparam logic [10:0] JMPV = 11'b11111_1110_10;
  localparam logic [10:0] RSTV = 11'b00000_1111_00;

  typedef struct packed {
    logic [10:0]      ctrl;
    logic [1:0]       st;
    logic             err;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
  logic id_uses_rt = 0, ex_mem_read = 0, mem_branch = 0, mem_zero = 0, mem_jump = 0;
  logic dmem_req = 0, dmem_ready = 0, clr_stats = 0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] pc_src_sel, state;
  logic err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_mem_read_i(ex_mem_read), .ex_write_reg_i(ex_write_reg),
    .mem_branch_i(mem_branch), .mem_zero_i(mem_zero), .mem_jump_i(mem_jump),
    .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready), .clr_stats_i(clr_stats),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
    .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
    .ex_mem_flush_o(ex_mem_flush), .mem_wb_flush_o(mem_wb_flush),
    .pc_src_sel_o(pc_src_sel), .state_o(state), .err_o(err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctrl",  32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
                          pc_src_sel}), 32'(e.ctrl));
        chk("state", 32'(state), 32'(e.st));
        chk("err",   32'(err), 32'(e.err));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(e.flush));
      end
    end
  end

  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic mrd, input logic [4:0] wr,
                     input logic br, input logic zr, input logic jp,
                     input logic rq, input logic rd, input logic cl,
                     input logic [10:0] ctrl, input logic [1:0] st, input logic er,
                     input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_mem_read = mrd; ex_write_reg = wr;
    mem_branch = br; mem_zero = zr; mem_jump = jp;
    dmem_req = rq; dmem_ready = rd; clr_stats = cl;
    e.ctrl = ctrl; e.st = st; e.err = er; e.stall = sc; e.flush = fc;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [10:0] ctrl, input logic [1:0] st, input logic er,
                      input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 0, ctrl, st, er, sc, fc);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_mem_read = 0; ex_write_reg = '0;
    mem_branch = 0; mem_zero = 0; mem_jump = 0;
    dmem_req = 0; dmem_ready = 0; clr_stats = 0;
    e.ctrl = RSTV; e.st = 2'b00; e.err = 1'b0; e.stall = '0; e.flush = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // load-use on rs: exactly one bubble
    cyc(5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0, LUV, 2'b00, 0, 2'd0, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd1, 2'd0);
    // false cases: $zero destination, rt match without rt use
    cyc(5'd0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 0, 0, 0, RUNV, 2'b00, 0, 2'd1, 2'd0);
    cyc(5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0, 0, 0, 0, RUNV, 2'b00, 0, 2'd1, 2'd0);
    // rt match with rt use stalls
    cyc(5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0, 0, 0, 0, LUV, 2'b00, 0, 2'd1, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd2, 2'd0);

    // taken branch coinciding with load-use: redirect wins, no stall counted
    cyc(5'd5, 5'd0, 0, 1, 5'd5, 1, 1, 0, 0, 0, 0, BRV, 2'b00, 0, 2'd2, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd2, 2'd1);
    // jump wins over branch
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 0, 0, 0, JMPV, 2'b00, 0, 2'd2, 2'd1);
    // untaken branch
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0, RUNV, 2'b00, 0, 2'd2, 2'd2);
    idle(RUNV, 2'b00, 0, 2'd2, 2'd2);

    // memory wait: 3 low cycles then ready
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b00, 0, 2'd0, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd1, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd2, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, RUNV, 2'b01, 0, 2'd3, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd3, 2'd0);

    // pending jump during wait is applied on the ready cycle
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 0, 0, FRZV, 2'b00, 0, 2'd0, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, 1, 0, JMPV, 2'b01, 0, 2'd1, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd1, 2'd1);

    // reset asserted mid-wait returns to RUN
    do_reset();
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b00, 0, 2'd0, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd1, 2'd0);
    do_reset();
    idle(RUNV, 2'b00, 0, 2'd0, 2'd0);

    // watchdog: 4 low cycles -> ERROR, ready afterwards ignored
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b00, 0, 2'd0, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd1, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd2, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0, 0, FRZV, 2'b01, 0, 2'd3, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 1, 0, FRZV, 2'b10, 1, 2'd3, 2'd0);
    cyc(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0, 1, 0, FRZV, 2'b10, 1, 2'd3, 2'd0);
    do_reset();
    idle(RUNV, 2'b00, 0, 2'd0, 2'd0);

    // stall counter saturation, then clear during a stall
    for (int i = 0; i < 5; i++)
      cyc(5'd9, 5'd0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 0, LUV, 2'b00, 0,
          (i > 3) ? 2'd3 : 2'(i), 2'd0);
    cyc(5'd9, 5'd0, 0, 1, 5'd9, 0, 0, 0, 0, 0, 1, LUV, 2'b00, 0, 2'd3, 2'd0);
    idle(RUNV, 2'b00, 0, 2'd0, 2'd0);

    begin
      int budget;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
